// File: rtl/n64_pi_address_decoder_pkg.sv
// Shared constants for the N64 PI address decoder: bank codes, address width,
// FSM encoding and the default region table reproducing the legacy bank map.
package n64_pi_address_decoder_pkg;

  localparam int PI_ADDR_W = 32;

  localparam logic [3:0] BANK_SDRAM    = 4'h0;
  localparam logic [3:0] BANK_CART     = 4'h1;
  localparam logic [3:0] BANK_EEPROM   = 4'h2;
  localparam logic [3:0] BANK_SD       = 4'h3;
  localparam logic [3:0] BANK_DDIPL    = 4'h4;
  localparam logic [3:0] BANK_SRAM     = 4'h5;
  localparam logic [3:0] BANK_FLASHRAM = 4'h6;
  localparam logic [3:0] BANK_INVALID  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_ACTIVE = 2'd2
  } pi_state_e;

  // Legacy map, most specific windows first so they shadow the ROM window.
  localparam int DEF_REGIONS = 6;
  localparam logic [31:0] DEF_BASE [DEF_REGIONS] = '{
    32'h0600_0000, 32'h0800_0000, 32'h1FFF_0000,
    32'h1FFE_0000, 32'h1FFD_0000, 32'h1000_0000};
  localparam logic [31:0] DEF_MASK [DEF_REGIONS] = '{
    32'hFE00_0000, 32'hFE00_0000, 32'hFFFF_0000,
    32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};
  localparam logic [3:0] DEF_BANK [DEF_REGIONS] = '{
    BANK_DDIPL, BANK_SRAM, BANK_CART, BANK_EEPROM, BANK_SD, BANK_SDRAM};
  localparam logic [DEF_REGIONS-1:0] DEF_PREFETCH = 6'b10_0001;

endpackage

// File: rtl/n64_pi_region_match.sv
// Combinational priority matcher: lowest enabled region whose masked base
// equals the address wins; a miss yields the invalid bank with prefetch set.
module n64_pi_region_match #(
  parameter int              NUM_REGIONS  = 8,
  parameter int              BANK_W       = 4,
  parameter logic [BANK_W-1:0] BANK_INVALID = 4'hF
) (
  input  logic [31:0]                   addr,
  input  logic [32*NUM_REGIONS-1:0]     region_base,
  input  logic [32*NUM_REGIONS-1:0]     region_mask,
  input  logic [BANK_W*NUM_REGIONS-1:0] region_bank,
  input  logic [NUM_REGIONS-1:0]        region_prefetch,
  input  logic [NUM_REGIONS-1:0]        region_enable,
  output logic [NUM_REGIONS-1:0]        hit,
  output logic [BANK_W-1:0]             bank,
  output logic                          prefetch
);

  logic [NUM_REGIONS-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_match
      assign match[gi] = region_enable[gi] &&
        (((addr ^ region_base[32*gi +: 32]) & region_mask[32*gi +: 32]) == 32'h0);
    end
  endgenerate

  // Walk from the top down so the lowest matching index is the last writer.
  always_comb begin
    hit      = '0;
    bank     = BANK_INVALID;
    prefetch = 1'b1;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit      = '0;
        hit[i]   = 1'b1;
        bank     = region_bank[BANK_W*i +: BANK_W];
        prefetch = region_prefetch[i];
      end
    end
  end

endmodule

// File: rtl/n64_pi_address_decoder.sv
// PI address assembly, burst auto-increment and registered region decode.
// Address and decode outputs are always updated on the same edge.
module n64_pi_address_decoder #(
  parameter int                NUM_REGIONS  = 8,
  parameter int                BANK_W       = 4,
  parameter logic [BANK_W-1:0] BANK_INVALID = n64_pi_address_decoder_pkg::BANK_INVALID
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_address_high_op,
  input  logic                          i_address_low_op,
  input  logic [15:0]                   i_n64_pi_ad,
  input  logic                          i_access,
  input  logic [32*NUM_REGIONS-1:0]     i_region_base,
  input  logic [32*NUM_REGIONS-1:0]     i_region_mask,
  input  logic [BANK_W*NUM_REGIONS-1:0] i_region_bank,
  input  logic [NUM_REGIONS-1:0]        i_region_prefetch,
  input  logic [NUM_REGIONS-1:0]        i_region_enable,
  output logic [31:0]                   o_address,
  output logic                          o_valid,
  output logic [BANK_W-1:0]             o_bank,
  output logic                          o_prefetch,
  output logic [NUM_REGIONS-1:0]        o_region_hit,
  output logic                          o_region_change
);

  import n64_pi_address_decoder_pkg::*;

  pi_state_e              state, state_nxt;
  logic [15:0]            addr_hi, addr_hi_nxt;
  logic [31:0]            addr_nxt;
  logic                   valid_nxt;
  logic                   decode_en;
  logic                   change_nxt;
  logic [NUM_REGIONS-1:0] hit_nxt;
  logic [BANK_W-1:0]      bank_nxt;
  logic                   prefetch_nxt;

  n64_pi_region_match #(
    .NUM_REGIONS  (NUM_REGIONS),
    .BANK_W       (BANK_W),
    .BANK_INVALID (BANK_INVALID)
  ) u_match (
    .addr            (addr_nxt),
    .region_base     (i_region_base),
    .region_mask     (i_region_mask),
    .region_bank     (i_region_bank),
    .region_prefetch (i_region_prefetch),
    .region_enable   (i_region_enable),
    .hit             (hit_nxt),
    .bank            (bank_nxt),
    .prefetch        (prefetch_nxt)
  );

  // The upper half is held aside so o_address only moves once a full address exists.
  always_comb begin
    state_nxt   = state;
    addr_hi_nxt = addr_hi;
    addr_nxt    = o_address;
    valid_nxt   = o_valid;
    decode_en   = 1'b0;
    change_nxt  = 1'b0;
    if (i_address_high_op) begin
      addr_hi_nxt = i_n64_pi_ad;
      state_nxt   = ST_HIGH;
      valid_nxt   = 1'b0;
    end else if (i_address_low_op && state == ST_HIGH) begin
      addr_nxt  = {addr_hi, i_n64_pi_ad[15:1], 1'b0};
      decode_en = 1'b1;
      state_nxt = ST_ACTIVE;
      valid_nxt = 1'b1;
    end else if (i_access && state == ST_ACTIVE) begin
      addr_nxt   = o_address + 32'd2;
      decode_en  = 1'b1;
      change_nxt = (hit_nxt != o_region_hit);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= ST_IDLE;
      addr_hi         <= '0;
      o_address       <= '0;
      o_valid         <= 1'b0;
      o_bank          <= BANK_INVALID;
      o_prefetch      <= 1'b1;
      o_region_hit    <= '0;
      o_region_change <= 1'b0;
    end else begin
      state           <= state_nxt;
      addr_hi         <= addr_hi_nxt;
      o_valid         <= valid_nxt;
      o_region_change <= change_nxt;
      if (decode_en) begin
        o_address    <= addr_nxt;
        o_bank       <= bank_nxt;
        o_prefetch   <= prefetch_nxt;
        o_region_hit <= hit_nxt;
      end
    end
  end

endmodule
